// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the core
// and the secondary (DMA/debug) master.
package dmem_arb_pkg;

   localparam int WAIT_CNT_W = 4;

   typedef enum logic {
      ARB   = 1'b0,
      LOCK1 = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } owner_t;

endpackage

// File: rtl/dmem_arb_resp.sv
// Read-response routing: remembers which port issued the load last cycle and
// steers the memory's read data to that port only.
module dmem_arb_resp
   import dmem_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_rd0,
   input  logic                  i_rd1,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   output logic                  o_p0_rvalid,
   output logic [DATA_WIDTH-1:0] o_p0_rdata,
   output logic                  o_p1_rvalid,
   output logic [DATA_WIDTH-1:0] o_p1_rdata
);

   owner_t r_owner;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner <= OWN_NONE;
      end else if (i_rd0) begin
         r_owner <= OWN_P0;
      end else if (i_rd1) begin
         r_owner <= OWN_P1;
      end else begin
         r_owner <= OWN_NONE;
      end
   end

   // Memory read data arrives one cycle after issue, so it is routed, not stored.
   assign o_p0_rvalid = (r_owner == OWN_P0);
   assign o_p1_rvalid = (r_owner == OWN_P1);
   assign o_p0_rdata  = o_p0_rvalid ? i_mem_rdata : '0;
   assign o_p1_rdata  = o_p1_rvalid ? i_mem_rdata : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: core (port 0) has fixed priority, port 1 is
// forced through after MAX_WAIT refusals and may lock the memory for RMW.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  p0_valid,
   output logic                  p0_ready,
   input  logic                  p0_wr_en,
   input  logic [DATA_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   input  logic [2:0]            p0_funct3,
   output logic                  p0_rvalid,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   output logic                  p0_stall,
   input  logic                  p1_valid,
   output logic                  p1_ready,
   input  logic                  p1_wr_en,
   input  logic [DATA_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   input  logic [2:0]            p1_funct3,
   input  logic                  p1_lock,
   output logic                  p1_rvalid,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic                  mem_wr_en,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [2:0]            mem_funct3,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output arb_state_t            dbg_state,
   output logic [WAIT_CNT_W-1:0] dbg_wait_cnt
);

   // Handshake: a request transfers (issues) in the cycle where valid and ready
   // are both high; the requester holds its payload stable until then.

   localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

   arb_state_t            r_state;
   logic [WAIT_CNT_W-1:0] r_wait_cnt;
   logic                  w_force1;
   logic                  w_issue0;
   logic                  w_issue1;

   always_comb begin
      w_force1 = p1_valid && (r_wait_cnt == MAX_WAIT_C);
      p0_ready = 1'b0;
      p1_ready = 1'b0;
      // Readies are gated by reset so nothing can issue while rst_n is low.
      if (rst_n) begin
         if (r_state == LOCK1) begin
            p1_ready = 1'b1;
         end else begin
            p0_ready = !w_force1;
            p1_ready = w_force1 || !p0_valid;
         end
      end
   end

   assign w_issue0 = p0_valid && p0_ready;
   assign w_issue1 = p1_valid && p1_ready;
   assign p0_stall = p0_valid && !p0_ready;

   always_comb begin
      mem_wr_en  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_funct3 = 3'b000;
      if (w_issue0) begin
         mem_wr_en  = p0_wr_en;
         mem_addr   = p0_addr;
         mem_wdata  = p0_wdata;
         mem_funct3 = p0_funct3;
      end else if (w_issue1) begin
         mem_wr_en  = p1_wr_en;
         mem_addr   = p1_addr;
         mem_wdata  = p1_wdata;
         mem_funct3 = p1_funct3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ARB;
         r_wait_cnt <= '0;
      end else begin
         case (r_state)
            ARB: begin
               if (w_issue1 && p1_lock) begin
                  r_state <= LOCK1;
               end
            end
            LOCK1: begin
               if (w_issue1 && !p1_lock) begin
                  r_state <= ARB;
               end
            end
            default: r_state <= ARB;
         endcase

         if ((r_state == LOCK1) || w_issue1 || !p1_valid) begin
            r_wait_cnt <= '0;
         end else if (r_wait_cnt < MAX_WAIT_C) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
      end
   end

   assign dbg_state    = r_state;
   assign dbg_wait_cnt = r_wait_cnt;

   dmem_arb_resp #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_resp (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rd0       (w_issue0 && !p0_wr_en),
      .i_rd1       (w_issue1 && !p1_wr_en),
      .i_mem_rdata (mem_rdata),
      .o_p0_rvalid (p0_rvalid),
      .o_p0_rdata  (p0_rdata),
      .o_p1_rvalid (p1_rvalid),
      .o_p1_rdata  (p1_rdata)
   );

   a_p0_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (p0_valid && !p0_ready) |=> (!p0_valid || $stable({p0_wr_en, p0_addr, p0_wdata, p0_funct3})));

   a_p1_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (p1_valid && !p1_ready) |=> (!p1_valid || $stable({p1_wr_en, p1_addr, p1_wdata, p1_funct3})));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: word memory model, read-response scoreboard and
// one task per scenario.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic          p0_valid, p0_ready, p0_wr_en, p0_rvalid, p0_stall;
   logic [DW-1:0] p0_addr, p0_wdata, p0_rdata;
   logic [2:0]    p0_funct3;
   logic          p1_valid, p1_ready, p1_wr_en, p1_rvalid, p1_lock;
   logic [DW-1:0] p1_addr, p1_wdata, p1_rdata;
   logic [2:0]    p1_funct3;
   logic          mem_wr_en;
   logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]    mem_funct3;
   arb_state_t    dbg_state;
   logic [3:0]    dbg_wait_cnt;

   logic [DW-1:0] mem [64];
   logic [DW:0]   exp_q [$];
   int            n_vec;
   int            n_err;

   dmem_arbiter #(.DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_wr_en(p0_wr_en),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_funct3(p0_funct3),
      .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_stall(p0_stall),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_wr_en(p1_wr_en),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_funct3(p1_funct3),
      .p1_lock(p1_lock), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
      .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
   );

   // ---------------- clock / memory model ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_addr[7:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:2]];
   end

   // ---------------- response scoreboard ----------------
   always @(negedge clk) begin
      logic [DW:0] exp_r;
      logic [DW:0] got_r;
      n_vec++;
      if ((!p0_rvalid && p0_rdata !== '0) || (!p1_rvalid && p1_rdata !== '0)) begin
         n_err++;
         $display("FAIL idle_rdata got p0=%h p1=%h want 0", p0_rdata, p1_rdata);
      end
      if (p0_rvalid || p1_rvalid) begin
         n_vec++;
         if (p0_rvalid && p1_rvalid) begin
            n_err++;
            $display("FAIL dual_rvalid got both rvalid want one");
         end else if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_rvalid got p0=%b p1=%b want none", p0_rvalid, p1_rvalid);
         end else begin
            exp_r = exp_q.pop_front();
            got_r = p0_rvalid ? {1'b0, p0_rdata} : {1'b1, p1_rdata};
            if (got_r !== exp_r) begin
               n_err++;
               $display("FAIL rdata got port%0d %h want port%0d %h",
                        got_r[DW], got_r[DW-1:0], exp_r[DW], exp_r[DW-1:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_p0(input logic v, input logic wr, input logic [DW-1:0] a,
                           input logic [DW-1:0] d, input logic [2:0] f3);
      p0_valid = v; p0_wr_en = wr; p0_addr = a; p0_wdata = d; p0_funct3 = f3;
   endtask

   task automatic drive_p1(input logic v, input logic wr, input logic [DW-1:0] a,
                           input logic [DW-1:0] d, input logic [2:0] f3, input logic lk);
      p1_valid = v; p1_wr_en = wr; p1_addr = a; p1_wdata = d; p1_funct3 = f3; p1_lock = lk;
   endtask

   task automatic idle_all();
      drive_p0(1'b0, 1'b0, '0, '0, 3'b000);
      drive_p1(1'b0, 1'b0, '0, '0, 3'b000, 1'b0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      drive_p0(1'b1, 1'b1, 32'h60, 32'hFFFF_FFFF, 3'b010);
      drive_p1(1'b1, 1'b1, 32'h64, 32'hEEEE_EEEE, 3'b010, 1'b0);
      repeat (2) @(negedge clk);
      n_vec++;
      if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_ready got %b%b want 00", p0_ready, p1_ready);
      end
      n_vec++;
      if (mem_wr_en !== 1'b0) begin
         n_err++; $display("FAIL reset_wr_en got %b want 0", mem_wr_en);
      end
      n_vec++;
      if (dbg_state !== ARB || dbg_wait_cnt !== 4'd0) begin
         n_err++; $display("FAIL reset_state got %0d/%0d want 0/0", dbg_state, dbg_wait_cnt);
      end
      step();
      idle_all();
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (mem[24] !== 32'h0 || mem[25] !== 32'h0) begin
         n_err++; $display("FAIL reset_no_write got %h %h want 0", mem[24], mem[25]);
      end
   endtask

   task automatic test_p0_load();
      step();
      drive_p0(1'b1, 1'b0, 32'h10, '0, 3'b010);
      @(negedge clk);
      n_vec++;
      if (p0_ready !== 1'b1 || mem_addr !== 32'h10 || mem_wr_en !== 1'b0 || mem_funct3 !== 3'b010) begin
         n_err++;
         $display("FAIL p0_load_issue got rdy=%b addr=%h we=%b f3=%b want 1/10/0/010",
                  p0_ready, mem_addr, mem_wr_en, mem_funct3);
      end
      exp_q.push_back({1'b0, 32'hDEAD_BEEF});
      step();
      idle_all();
      @(negedge clk);
      n_vec++;
      if (p0_rvalid !== 1'b1 || p1_rvalid !== 1'b0) begin
         n_err++; $display("FAIL p0_load_rvalid got %b%b want 10", p0_rvalid, p1_rvalid);
      end
      @(negedge clk);
      n_vec++;
      if (p0_rvalid !== 1'b0) begin
         n_err++; $display("FAIL p0_load_pulse got %b want 0", p0_rvalid);
      end
   endtask

   task automatic test_starvation();
      logic e1;
      step();
      drive_p0(1'b1, 1'b1, 32'h80, 32'hA0A0_A0A0, 3'b010);
      drive_p1(1'b1, 1'b1, 32'h84, 32'hB1B1_B1B1, 3'b010, 1'b0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         e1 = ((c % 5) == 4);
         n_vec++;
         if (p0_ready !== !e1 || p1_ready !== e1 || p0_stall !== e1) begin
            n_err++;
            $display("FAIL starve_ready c=%0d got r0=%b r1=%b st=%b want r1=%b", c,
                     p0_ready, p1_ready, p0_stall, e1);
         end
         n_vec++;
         if (mem_addr !== (e1 ? 32'h84 : 32'h80) || dbg_wait_cnt !== 4'(c % 5)) begin
            n_err++;
            $display("FAIL starve_issue c=%0d got addr=%h cnt=%0d want cnt=%0d", c,
                     mem_addr, dbg_wait_cnt, c % 5);
         end
      end
      step();
      idle_all();
      @(negedge clk);
      n_vec++;
      if (dbg_wait_cnt !== 4'd0) begin
         n_err++; $display("FAIL starve_cnt_clear got %0d want 0", dbg_wait_cnt);
      end
   endtask

   task automatic test_lock();
      step();
      drive_p1(1'b1, 1'b0, 32'h20, '0, 3'b010, 1'b1);
      @(negedge clk);
      n_vec++;
      if (p1_ready !== 1'b1 || mem_addr !== 32'h20 || mem_wr_en !== 1'b0) begin
         n_err++; $display("FAIL lock_issue got rdy=%b addr=%h we=%b want 1/20/0",
                           p1_ready, mem_addr, mem_wr_en);
      end
      exp_q.push_back({1'b1, 32'hCAFE_0020});
      step();
      drive_p1(1'b0, 1'b0, '0, '0, 3'b000, 1'b0);
      drive_p0(1'b1, 1'b1, 32'h30, 32'h5555_AAAA, 3'b010);
      @(negedge clk);
      n_vec++;
      if (dbg_state !== LOCK1 || p0_ready !== 1'b0 || p0_stall !== 1'b1 || mem_wr_en !== 1'b0) begin
         n_err++; $display("FAIL lock_hold got st=%0d r0=%b stall=%b we=%b want 1/0/1/0",
                           dbg_state, p0_ready, p0_stall, mem_wr_en);
      end
      step();
      drive_p1(1'b1, 1'b1, 32'h34, 32'h1234_5678, 3'b010, 1'b0);
      @(negedge clk);
      n_vec++;
      if (p0_ready !== 1'b0 || p1_ready !== 1'b1 || mem_wr_en !== 1'b1 ||
          mem_addr !== 32'h34 || mem_wdata !== 32'h1234_5678) begin
         n_err++; $display("FAIL lock_release got r0=%b r1=%b we=%b addr=%h wd=%h want 0/1/1/34/12345678",
                           p0_ready, p1_ready, mem_wr_en, mem_addr, mem_wdata);
      end
      step();
      drive_p1(1'b0, 1'b0, '0, '0, 3'b000, 1'b0);
      @(negedge clk);
      n_vec++;
      if (dbg_state !== ARB || p0_ready !== 1'b1 || mem_wr_en !== 1'b1 ||
          mem_addr !== 32'h30 || mem_wdata !== 32'h5555_AAAA) begin
         n_err++; $display("FAIL lock_p0_after got st=%0d r0=%b we=%b addr=%h wd=%h want 0/1/1/30/5555aaaa",
                           dbg_state, p0_ready, mem_wr_en, mem_addr, mem_wdata);
      end
      step();
      idle_all();
      @(negedge clk);
      n_vec++;
      if (mem[12] !== 32'h5555_AAAA || mem[13] !== 32'h1234_5678) begin
         n_err++; $display("FAIL lock_mem got %h %h want 5555aaaa 12345678", mem[12], mem[13]);
      end
   endtask

   task automatic test_back_to_back();
      step();
      drive_p0(1'b1, 1'b0, 32'h0, '0, 3'b010);
      @(negedge clk);
      n_vec++;
      if (p0_ready !== 1'b1) begin
         n_err++; $display("FAIL b2b_p0_issue got %b want 1", p0_ready);
      end
      exp_q.push_back({1'b0, 32'h1111_1111});
      step();
      drive_p0(1'b0, 1'b0, '0, '0, 3'b000);
      drive_p1(1'b1, 1'b0, 32'h4, '0, 3'b010, 1'b0);
      @(negedge clk);
      n_vec++;
      if (p1_ready !== 1'b1 || p0_rvalid !== 1'b1) begin
         n_err++; $display("FAIL b2b_step1 got r1=%b rv0=%b want 1/1", p1_ready, p0_rvalid);
      end
      exp_q.push_back({1'b1, 32'h2222_2222});
      step();
      drive_p1(1'b0, 1'b0, '0, '0, 3'b000, 1'b0);
      drive_p0(1'b1, 1'b0, 32'h8, '0, 3'b010);
      @(negedge clk);
      n_vec++;
      if (p0_ready !== 1'b1 || p1_rvalid !== 1'b1) begin
         n_err++; $display("FAIL b2b_step2 got r0=%b rv1=%b want 1/1", p0_ready, p1_rvalid);
      end
      exp_q.push_back({1'b0, 32'h3333_3333});
      step();
      idle_all();
      @(negedge clk);
      n_vec++;
      if (p0_rvalid !== 1'b1) begin
         n_err++; $display("FAIL b2b_step3 got rv0=%b want 1", p0_rvalid);
      end
      @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL b2b_drain got %0d pending want 0", exp_q.size());
      end
   endtask

   task automatic test_byte_store();
      step();
      drive_p0(1'b1, 1'b1, 32'h50, 32'h0000_00AB, 3'b000);
      @(negedge clk);
      n_vec++;
      if (mem_wr_en !== 1'b1 || mem_funct3 !== 3'b000 || mem_wdata !== 32'hAB || mem_addr !== 32'h50) begin
         n_err++; $display("FAIL byte_store got we=%b f3=%b wd=%h addr=%h want 1/000/ab/50",
                           mem_wr_en, mem_funct3, mem_wdata, mem_addr);
      end
      step();
      idle_all();
      @(negedge clk);
      n_vec++;
      if (mem_wr_en !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || mem_funct3 !== 3'b000 ||
          p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
         n_err++; $display("FAIL byte_store_idle got we=%b addr=%h wd=%h f3=%b rv=%b%b want all 0",
                           mem_wr_en, mem_addr, mem_wdata, mem_funct3, p0_rvalid, p1_rvalid);
      end
   endtask

   task automatic test_reset_mid();
      step();
      drive_p0(1'b1, 1'b0, 32'h10, '0, 3'b010);
      drive_p1(1'b1, 1'b0, 32'h20, '0, 3'b010, 1'b1);
      @(negedge clk);
      n_vec++;
      if (p0_ready !== 1'b1 || p1_ready !== 1'b0 || dbg_wait_cnt !== 4'd0) begin
         n_err++; $display("FAIL rmid_prio got r0=%b r1=%b cnt=%0d want 1/0/0",
                           p0_ready, p1_ready, dbg_wait_cnt);
      end
      exp_q.push_back({1'b0, 32'hDEAD_BEEF});
      step();
      drive_p0(1'b0, 1'b0, '0, '0, 3'b000);
      @(negedge clk);
      n_vec++;
      if (p1_ready !== 1'b1 || dbg_wait_cnt !== 4'd1) begin
         n_err++; $display("FAIL rmid_p1_issue got r1=%b cnt=%0d want 1/1", p1_ready, dbg_wait_cnt);
      end
      step();
      idle_all();
      rst_n = 1'b0;
      @(negedge clk);
      n_vec++;
      if (p1_rvalid !== 1'b0 || p0_ready !== 1'b0 || p1_ready !== 1'b0 || dbg_state !== ARB) begin
         n_err++; $display("FAIL rmid_in_reset got rv1=%b r0=%b r1=%b st=%0d want 0/0/0/0",
                           p1_rvalid, p0_ready, p1_ready, dbg_state);
      end
      step();
      rst_n = 1'b1;
      drive_p0(1'b1, 1'b0, 32'h10, '0, 3'b010);
      @(negedge clk);
      n_vec++;
      if (dbg_state !== ARB || dbg_wait_cnt !== 4'd0 || p0_ready !== 1'b1 || p1_rvalid !== 1'b0) begin
         n_err++; $display("FAIL rmid_after got st=%0d cnt=%0d r0=%b rv1=%b want 0/0/1/0",
                           dbg_state, dbg_wait_cnt, p0_ready, p1_rvalid);
      end
      exp_q.push_back({1'b0, 32'hDEAD_BEEF});
      step();
      idle_all();
      repeat (2) @(negedge clk);
   endtask

   // ---------------- main sequence / report ----------------
   initial begin
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[0] = 32'h1111_1111;
      mem[1] = 32'h2222_2222;
      mem[2] = 32'h3333_3333;
      mem[4] = 32'hDEAD_BEEF;
      mem[8] = 32'hCAFE_0020;
      rst_n = 1'b0;
      idle_all();

      test_reset();
      test_p0_load();
      test_starvation();
      test_lock();
      test_back_to_back();
      test_byte_store();
      test_reset_mid();

      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL final_drain got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (core MEM stage, load/store) and port 1 (secondary master: DMA/debug loader).
- Sits between the requesters and data_mem; passes funct3 through so the memory applies byte/half/word sizing.
- Fixed priority to the core, with a starvation bound for port 1 and a lock for atomic read-modify-write sequences on port 1.

Parameters:
- DATA_WIDTH, 32, data and address width.
- MAX_WAIT, 4, cycles port 1 may be refused while valid before it is forced through (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_valid  in  1  core request valid.
- p0_ready  out  1  core request accepted this cycle.
- p0_wr_en  in  1  1 = store, 0 = load.
- p0_addr  in  DATA_WIDTH  byte address.
- p0_wdata  in  DATA_WIDTH  store data.
- p0_funct3  in  3  access size/sign code.
- p0_rvalid  out  1  load data valid on p0_rdata.
- p0_rdata  out  DATA_WIDTH  load data.
- p0_stall  out  1  p0_valid & ~p0_ready, to the hazard unit.
- p1_valid, p1_ready, p1_wr_en, p1_addr, p1_wdata, p1_funct3, p1_rvalid, p1_rdata  as port 0.
- p1_lock  in  1  sampled with an accepted p1 request; holds exclusive grant.
- mem_wr_en  out  1  write strobe to data memory.
- mem_addr  out  DATA_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_funct3  out  3  memory access size.
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after the read is issued.

Behaviour:
- Issue = valid & ready on a port. At most one issue per cycle. The winning port's addr, wdata and funct3 drive mem_*.
- mem_wr_en = issue & wr_en. With no issue, mem_wr_en = 0 and mem_addr/mem_wdata/mem_funct3 = 0.
- State ARB:
  - force1 = p1_valid & (wait_cnt == MAX_WAIT).
  - p0_ready = ~force1.
  - p1_ready = force1 | ~p0_valid.
- State LOCK1:
  - p0_ready = 0; p1_ready = 1.
  - Port 0 is held off until the lock releases.
- Transitions:
  - ARB -> LOCK1 when p1 issues with p1_lock = 1.
  - LOCK1 -> ARB when p1 issues with p1_lock = 0; that request is still performed.
  - LOCK1 with p1_valid = 0 holds state.
- wait_cnt (4 bits):
  - +1 per ARB cycle with p1_valid & ~p1_ready, saturating at MAX_WAIT.
  - Cleared on p1 issue, when p1_valid = 0, and in LOCK1.
- Read response: a load issued in cycle N raises <port>_rvalid for exactly one cycle in N+1, with <port>_rdata = mem_rdata.
  - The owner is registered at issue; the other port's rvalid = 0 and rdata = 0.
  - Stores produce no response.
  - Back-to-back loads from alternating ports return in order, one per cycle.
- Simultaneous p0 and p1 requests outside force1/LOCK1: p0 wins, p1 waits and counts.
- Reset (async, any time):
  - state = ARB, wait_cnt = 0.
  - Both rvalid = 0, rdata = 0; pending response discarded.
  - Both ready = 0 while rst_n = 0; mem_wr_en = 0.
  - No write may reach memory during reset.
- Requester contract: a requester keeps its payload stable while valid & ~ready. An assertion checks this.

Decomposition:
- Package dmem_arb_pkg:
  - typedef arb_state_t {ARB, LOCK1}.
  - typedef owner_t {OWN_NONE, OWN_P0, OWN_P1}.
  - constant WAIT_CNT_W = 4.
- Optional sub-module dmem_arb_resp: registered owner, rvalid and rdata routing.
- Everything else stays in one module.

Test Plan:
- p0 load addr 0x10, memory holds 0xDEADBEEF -> p0_ready = 1 in cycle N; p0_rvalid = 1 with 0xDEADBEEF in N+1 only; p1_rvalid stays 0.
- p0 and p1 valid continuously, MAX_WAIT = 4 -> p0 issues cycles 0-3; cycle 4 p1 issues with p0_stall = 1; wait_cnt returns to 0; pattern repeats every 5 cycles.
- p1 locked load to 0x20, then p0 store plus p1 store with lock = 0 -> p0_ready = 0 throughout; p1 store performs; the next cycle p0 store issues (mem_wr_en = 1, addr p0_addr).
- Alternating loads p0 @0x0, p1 @0x4, p0 @0x8 -> rvalid pulses on p0, p1, p0 in consecutive cycles with the correct data each.
- p0 byte store (funct3 = 000, wdata = 0xAB) -> mem_funct3 = 000, mem_wr_en one cycle; no rvalid on either port.
- rst_n low in the cycle after a p1 load issue -> p1_rvalid never asserts; after release, state = ARB and wait_cnt = 0; an immediate p0 request is granted.
